// File: rtl/router_pkg.sv
// Shared types and helpers for the 1x3 router packet-sequencing controller.
package router_pkg;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned ADDR_W    = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_e;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic full_state;
        logic laf_state;
        logic rst_in_reg;
        logic write_enb_reg;
        logic busy;
    } fsm_out_t;

    // Moore output decode of a state.
    function automatic fsm_out_t decode_state(state_e s);
        fsm_out_t o;
        o               = '0;
        o.detect_add    = (s == DECODE_ADDRESS);
        o.lfd_state     = (s == LOAD_FIRST_DATA);
        o.ld_state      = (s == LOAD_DATA);
        o.full_state    = (s == FIFO_FULL_STATE);
        o.laf_state     = (s == LOAD_AFTER_FULL);
        o.rst_in_reg    = (s == CHECK_PARITY_ERROR);
        o.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
        o.busy          = (s != DECODE_ADDRESS) && (s != LOAD_DATA);
        return o;
    endfunction

    // Per-port flag select; the invalid address selects nothing.
    function automatic logic pick_flag(logic [ADDR_W-1:0] a, logic [NUM_PORTS-1:0] f);
        logic r;
        case (a)
            2'd0:    r = f[0];
            2'd1:    r = f[1];
            2'd2:    r = f[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Control bundle between the router input port, register block and router_fsm.
interface router_fsm_if;

    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       full_state;
    logic       laf_state;
    logic       rst_in_reg;
    logic       write_enb_reg;
    logic       busy;

    modport master (
        output pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, full_state, laf_state,
               rst_in_reg, write_enb_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, full_state, laf_state,
               rst_in_reg, write_enb_reg, busy
    );

endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller: header decode, drain wait, load/full/parity
// sequencing. All outputs are registered decodes of the state.
module router_fsm
    import router_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    router_fsm_if.slave  bus
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q,  addr_d;
    fsm_out_t              out_q;

    logic [NUM_PORTS-1:0]  empty_vec;
    logic [NUM_PORTS-1:0]  soft_vec;
    logic                  hdr_ok;
    logic                  hdr_empty;
    logic                  sel_empty;
    logic                  sel_soft;

    assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

    // Header decode looks at the live address; later states use the latch.
    assign hdr_ok    = bus.pkt_valid && (bus.data_in != ADDR_INVALID);
    assign hdr_empty = pick_flag(bus.data_in, empty_vec);
    assign sel_empty = pick_flag(addr_q, empty_vec);
    assign sel_soft  = pick_flag(addr_q, soft_vec);

    // Next-state and address-latch logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    addr_d  = bus.data_in;
                    state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // A read-timeout on the selected FIFO aborts the packet from any busy state.
        if (sel_soft && (state_q != DECODE_ADDRESS)) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
            out_q   <= decode_state(DECODE_ADDRESS);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            out_q   <= decode_state(state_d);
        end
    end

    assign bus.detect_add    = out_q.detect_add;
    assign bus.lfd_state     = out_q.lfd_state;
    assign bus.ld_state      = out_q.ld_state;
    assign bus.full_state    = out_q.full_state;
    assign bus.laf_state     = out_q.laf_state;
    assign bus.rst_in_reg    = out_q.rst_in_reg;
    assign bus.write_enb_reg = out_q.write_enb_reg;
    assign bus.busy          = out_q.busy;

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm.
module tb_router_fsm;

    // Output vector order: detect_add lfd ld full laf rst_in_reg write_enb busy
    localparam logic [7:0] O_DEC  = 8'h80;
    localparam logic [7:0] O_LFD  = 8'h41;
    localparam logic [7:0] O_LD   = 8'h22;
    localparam logic [7:0] O_FULL = 8'h11;
    localparam logic [7:0] O_LAF  = 8'h0B;
    localparam logic [7:0] O_LP   = 8'h03;
    localparam logic [7:0] O_CHK  = 8'h05;
    localparam logic [7:0] O_WAIT = 8'h01;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   wen_cycles;

    router_fsm_if bus ();

    router_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] obs;
    assign obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state,
                  bus.laf_state, bus.rst_in_reg, bus.write_enb_reg, bus.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.write_enb_reg) wen_cycles++;
    endtask

    task automatic step_chk(input string tag, input logic [7:0] exp);
        step();
        check(tag, 32'(obs), 32'(exp));
    endtask

    task automatic idle_inputs();
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        wen_cycles = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset_out", 32'(obs), 32'(O_DEC));
        check("reset_addr", 32'(dut.addr_q), 32'd0);

        // Packet to port 1, FIFO empty, 4 payload bytes.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        step_chk("p1_lfd", O_LFD);
        wen_cycles = 0;
        step_chk("p1_ld1", O_LD);
        step_chk("p1_ld2", O_LD);
        step_chk("p1_ld3", O_LD);
        step_chk("p1_ld4", O_LD);
        bus.pkt_valid = 1'b0;
        step_chk("p1_lp", O_LP);
        step_chk("p1_chk", O_CHK);
        step_chk("p1_dec", O_DEC);
        check("p1_wen_cycles", 32'(wen_cycles), 32'd5);
        check("p1_addr", 32'(dut.addr_q), 32'd1);

        // Port 2 not empty for 6 cycles.
        bus.pkt_valid    = 1'b1;
        bus.data_in      = 2'd2;
        bus.fifo_empty_2 = 1'b0;
        step_chk("p2_wait0", O_WAIT);
        bus.pkt_valid = 1'b0;
        for (int i = 0; i < 5; i++) step_chk("p2_wait", O_WAIT);
        check("p2_addr", 32'(dut.addr_q), 32'd2);
        bus.fifo_empty_2 = 1'b1;
        step_chk("p2_lfd", O_LFD);
        bus.pkt_valid = 1'b1;
        step_chk("p2_ld", O_LD);

        // Full and end-of-packet together: full wins; then 3 full cycles.
        bus.fifo_full = 1'b1;
        bus.pkt_valid = 1'b0;
        step_chk("full_prio", O_FULL);
        step_chk("full_2", O_FULL);
        step_chk("full_3", O_FULL);
        bus.fifo_full = 1'b0;
        bus.pkt_valid = 1'b1;
        step_chk("laf_a", O_LAF);
        step_chk("laf_to_ld", O_LD);
        bus.fifo_full = 1'b1;
        step_chk("full_b", O_FULL);
        bus.fifo_full = 1'b0;
        step_chk("laf_b", O_LAF);
        bus.low_pkt_valid = 1'b1;
        step_chk("laf_low_lp", O_LP);
        bus.low_pkt_valid = 1'b0;
        step_chk("lp_chk", O_CHK);
        bus.fifo_full = 1'b1;
        step_chk("chk_full", O_FULL);

        // Reset mid-packet with inputs still asserting.
        reset = 1'b1;
        step_chk("mid_reset", O_DEC);
        reset = 1'b0;
        check("mid_reset_addr", 32'(dut.addr_q), 32'd0);
        bus.fifo_full = 1'b0;

        // parity_done path out of LOAD_AFTER_FULL.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd2;
        step_chk("pd_lfd", O_LFD);
        step_chk("pd_ld", O_LD);
        bus.fifo_full = 1'b1;
        step_chk("pd_full", O_FULL);
        bus.fifo_full = 1'b0;
        step_chk("pd_laf", O_LAF);
        bus.parity_done   = 1'b1;
        bus.low_pkt_valid = 1'b1;
        bus.pkt_valid     = 1'b0;
        step_chk("pd_dec", O_DEC);
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;

        // Invalid address 3 is dropped.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd3;
        step_chk("a3_stay1", O_DEC);
        step_chk("a3_stay2", O_DEC);
        check("a3_addr", 32'(dut.addr_q), 32'd2);

        // Soft reset: selected port aborts, other ports ignored.
        bus.data_in = 2'd0;
        step_chk("s0_lfd", O_LFD);
        step_chk("s0_ld", O_LD);
        bus.soft_reset_1 = 1'b1;
        step_chk("s1_ignored", O_LD);
        bus.soft_reset_1 = 1'b0;
        bus.soft_reset_0 = 1'b1;
        bus.pkt_valid    = 1'b0;
        step_chk("s0_abort", O_DEC);
        check("s0_addr", 32'(dut.addr_q), 32'd0);
        bus.pkt_valid = 1'b1;
        step_chk("s0_in_decode", O_LFD);
        bus.soft_reset_0 = 1'b0;
        bus.pkt_valid    = 1'b0;
        step_chk("s0_ld_after", O_LD);
        step_chk("s0_lp_after", O_LP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-sequencing controller for the 1x3 router. Decodes the header address, waits for the destination FIFO to drain, and steps the register block through header load, payload load, full-stall recovery, parity capture and parity check. Sits between the input port and the register/synchronizer blocks; every one of its outputs is a registered Moore decode of its state.

## Interface

Parameters:
- NUM_PORTS, 3, number of destination FIFOs (fixed at 3; addresses 0..2 valid, address 3 invalid)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; forces DECODE_ADDRESS
- pkt_valid  in  1  input byte stream valid; deasserts on the parity byte
- data_in  in  2  header address bits (data_in[1:0] of the input byte)
- fifo_full  in  1  full flag of the currently selected FIFO
- fifo_empty_0/1/2  in  1 each  empty flags of FIFO 0/1/2
- soft_reset_0/1/2  in  1 each  read-timeout soft reset of FIFO 0/1/2
- parity_done  in  1  from register block: parity byte captured
- low_pkt_valid  in  1  from register block: pkt_valid fell during a load
- detect_add  out  1  state == DECODE_ADDRESS
- lfd_state  out  1  state == LOAD_FIRST_DATA
- ld_state  out  1  state == LOAD_DATA
- full_state  out  1  state == FIFO_FULL_STATE
- laf_state  out  1  state == LOAD_AFTER_FULL
- rst_in_reg  out  1  state == CHECK_PARITY_ERROR
- write_enb_reg  out  1  LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL
- busy  out  1  high in every state except DECODE_ADDRESS and LOAD_DATA

## Operation

- Address latch addr_q[1:0]: loaded from data_in in DECODE_ADDRESS when pkt_valid && data_in != 3; held otherwise. Reset value 0.
- sel_empty = fifo_empty_{addr_q}; sel_soft = soft_reset_{addr_q}; in DECODE_ADDRESS the empty check uses data_in directly.
- Transitions (priority: reset > sel_soft > table):
  - DECODE_ADDRESS: pkt_valid, addr != 3, fifo_empty[data_in] -> LOAD_FIRST_DATA; pkt_valid, addr != 3, not empty -> WAIT_TILL_EMPTY; otherwise stay. Address 3 is dropped (no state change).
  - WAIT_TILL_EMPTY: sel_empty -> LOAD_FIRST_DATA; otherwise stay.
  - LOAD_FIRST_DATA: -> LOAD_DATA unconditionally.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
  - LOAD_PARITY: -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- sel_soft in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next cycle; addr_q unchanged. Soft resets of non-selected FIFOs are ignored.

## Timing

- Reset values: state DECODE_ADDRESS; detect_add=1; all other outputs 0; addr_q=0.
- Outputs are registered state decodes; they change one cycle after the qualifying input edge. No combinational input-to-output path.
- Minimum packet path: header accepted -> lfd_state 1 cycle later -> ld_state next cycle.
- Parity: pkt_valid low sampled in LOAD_DATA -> LOAD_PARITY (1 cycle) -> CHECK_PARITY_ERROR (1 cycle) -> DECODE_ADDRESS; 3 cycles after pkt_valid falls, detect_add is high again.
- fifo_full and !pkt_valid together in LOAD_DATA: fifo_full wins.
- sel_soft together with any other transition condition: sel_soft wins.
- reset asserted mid-packet: DECODE_ADDRESS on the next edge regardless of inputs.

## Structure

- Shared package router_pkg: state enum (3-bit, binary, DECODE_ADDRESS = 0), ADDR_INVALID = 2'd3, NUM_PORTS.
- Single module; no sub-module. One state register, one next-state block, one registered output decode, one addr_q register.

## Test plan

- Header addr 1, fifo_empty_1=1, 4 payload bytes, pkt_valid falls -> states DECODE, LFD, LOAD_DATA x4, LOAD_PARITY, CHECK, DECODE; write_enb_reg high for 5 cycles; busy low during LOAD_DATA.
- Header addr 2, fifo_empty_2=0 for 6 cycles, then 1 -> WAIT_TILL_EMPTY for 6 cycles with busy=1, then LFD.
- Header addr 3 with pkt_valid=1 -> stays DECODE_ADDRESS; detect_add stays 1; addr_q unchanged.
- fifo_full rises in LOAD_DATA for 3 cycles -> FIFO_FULL_STATE x3, LAF; with low_pkt_valid=1 -> LOAD_PARITY; with parity_done=1 -> DECODE.
- soft_reset_0 pulse while in LOAD_DATA for addr 0 -> DECODE next cycle; soft_reset_1 pulse at the same point -> no effect.
- reset asserted during FIFO_FULL_STATE -> DECODE next edge; detect_add=1, all other outputs 0.
